// File: rtl/ex_mult_div_unit.sv
// EX-stage iterative multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply, restoring divide, sign fix on commit.
module ex_mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] busAEx,
  input  logic [WIDTH-1:0] busBEx,
  input  logic             flush,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] wrData,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic               is_div_q;
  logic               neg_a;
  logic               neg_b;
  logic               dz;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mb;
  logic [CNT_W-1:0]   cnt;

  logic               sgn;
  logic               b_zero;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     madd;
  logic [WIDTH:0]     rsh;
  logic [WIDTH:0]     rsub;
  logic               qbit;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] div_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign busy   = (state != S_IDLE);
  assign sgn    = ~op[0];
  assign b_zero = (busBEx == '0);
  assign a_abs  = (sgn && busAEx[WIDTH-1]) ? -busAEx : busAEx;
  assign b_abs  = (sgn && busBEx[WIDTH-1]) ? -busBEx : busBEx;

  // acc = {partial product, remaining multiplier bits}
  assign madd    = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc[0] ? mb : '0)};
  assign mul_nxt = {madd, acc[WIDTH-1:1]};

  // acc = {partial remainder, dividend bits then quotient bits}
  assign rsh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign rsub    = rsh - {1'b0, mb};
  assign qbit    = ~rsub[WIDTH];
  assign div_nxt = {(qbit ? rsub[WIDTH-1:0] : rsh[WIDTH-1:0]),
                    acc[WIDTH-2:0], qbit};

  assign prod = (neg_a ^ neg_b) ? -acc : acc;
  assign quot = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      is_div_q  <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      dz        <= 1'b0;
      acc       <= '0;
      mb        <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done      <= 1'b0;
      divByZero <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (hiWrite) hi <= wrData;
          if (loWrite) lo <= wrData;
          if (start && !flush) begin
            is_div_q <= op[1];
            neg_a    <= sgn & busAEx[WIDTH-1];
            neg_b    <= sgn & busBEx[WIDTH-1];
            acc      <= {{WIDTH{1'b0}}, a_abs};
            mb       <= b_abs;
            cnt      <= '0;
            dz       <= op[1] & b_zero;
            state    <= (op[1] && b_zero) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc <= is_div_q ? div_nxt : mul_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (dz) begin
              divByZero <= 1'b1;
            end else if (is_div_q) begin
              hi <= rem;
              lo <= quot;
            end else begin
              {hi, lo} <= prod;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mult_div_unit.sv
// Directed plus random bench for ex_mult_div_unit.
// Reference results come from plain 64-bit arithmetic.
module tb_ex_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] busAEx;
  logic [31:0] busBEx;
  logic        flush;
  logic        hiWrite;
  logic        loWrite;
  logic [31:0] wrData;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  ex_mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .busAEx(busAEx), .busBEx(busBEx), .flush(flush),
    .hiWrite(hiWrite), .loWrite(loWrite), .wrData(wrData),
    .busy(busy), .done(done), .divByZero(divByZero),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {divide-by-zero, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned p;
    logic [64:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      2'b00: begin
        q = sa * sb;
        res = {1'b0, q[63:0]};
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        res = {1'b0, p[63:0]};
      end
      2'b10: begin
        if (b == 0) res = {1'b1, mhi, mlo};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {1'b0, r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {1'b1, mhi, mlo};
        else res = {1'b0, a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic mt(input logic [31:0] v);
    hiWrite = 1'b1;
    loWrite = 1'b1;
    wrData = v;
    @(negedge clk);
    hiWrite = 1'b0;
    loWrite = 1'b0;
    mhi = v;
    mlo = v;
    check("mt_hi", {32'b0, hi}, {32'b0, v});
    check("mt_lo", {32'b0, lo}, {32'b0, v});
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit hw);
    logic [64:0] e;
    int n, bc;
    e = model(o, a, b);
    start = 1'b1;
    op = o;
    busAEx = a;
    busBEx = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    bc = 0;
    for (int k = 0; k < 40; k++) begin
      n++;
      if (hw && n == 3) begin
        hiWrite = 1'b1;
        wrData = 32'hDEAD_BEEF;
      end
      if (hw && n == 4) begin
        hiWrite = 1'b0;
        check("hi_busy_write", {32'b0, hi}, {32'b0, mhi});
      end
      if (done) break;
      if (busy) bc++;
      @(negedge clk);
    end
    check("latency", 64'(n), e[64] ? 64'd2 : 64'd34);
    check("busy_cycles", 64'(bc), e[64] ? 64'd1 : 64'd33);
    check("dbz", {63'b0, divByZero}, {63'b0, e[64]});
    check("hilo", {hi, lo}, e[63:0]);
    mhi = e[63:32];
    mlo = e[31:0];
    @(negedge clk);
    check("done_pulse", {62'b0, done, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0] ro;
    bit seen_done;
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'b00;
    busAEx = '0;
    busBEx = '0;
    flush = 1'b0;
    hiWrite = 1'b0;
    loWrite = 1'b0;
    wrData = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", {59'b0, busy, done, divByZero, 2'b0}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    mt(32'h1234);
    run_op(2'b11, 32'd5, 32'd0, 1'b0);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);

    // Flushed multiply with an ignored second start
    seen_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      start = (c == 0 || c == 5);
      op = 2'b01;
      busAEx = (c == 0) ? 32'd6 : 32'd99;
      busBEx = (c == 0) ? 32'd7 : 32'd55;
      flush = (c == 10);
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    start = 1'b0;
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("flush_no_done", {63'b0, seen_done}, 64'd0);
    check("flush_hilo", {hi, lo}, {mhi, mlo});
    run_op(2'b01, 32'd6, 32'd7, 1'b0);
    check("mul42", {hi, lo}, 64'd42);

    run_op(2'b00, 32'h0001_2345, 32'hFFFF_0003, 1'b1);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 1) rb = 32'd0;
      if (i % 5 == 2) rb = 32'($urandom_range(1, 20));
      if (i % 7 == 3) ra = 32'h8000_0000;
      run_op(ro, ra, rb, 1'b0);
    end

    // Asynchronous reset in the middle of a calculation
    start = 1'b1;
    op = 2'b01;
    busAEx = 32'd1000;
    busBEx = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", {63'b0, busy}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", {61'b0, busy, done, divByZero}, 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(2'b11, 32'd1000, 32'd33, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
